// File: rtl/rf_pkg.sv
// Shared sizing and entry layouts for the rename register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

   localparam int DATA_W    = 32;
   localparam int ARF_DEPTH = 32;
   localparam int AREG_W    = $clog2(ARF_DEPTH);
   localparam int RRF_DEPTH = 8;
   localparam int TAG_W     = $clog2(RRF_DEPTH);

   // Architectural entry: committed value plus the rename it is waiting on.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              busy;
      logic [TAG_W-1:0]  tag;
   } arf_entry_t;

   // Rename entry: speculative result slot.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              alloc;
      logic              valid;
   } rrf_entry_t;

endpackage

// File: rtl/rrf_free_list.sv
// Finds the two lowest-index free rename entries.
// Latency: combinational.
// Backpressure: none; o_vld0/o_vld1 low when fewer than one/two entries are free.
// Ports: i_alloc   per-entry allocated flags
//        o_idx0    lowest free index,        o_vld0 it exists
//        o_idx1    second-lowest free index, o_vld1 it exists
module rrf_free_list
   import rf_pkg::*;
(
   input  logic [RRF_DEPTH-1:0] i_alloc,
   output logic [TAG_W-1:0]     o_idx0,
   output logic                 o_vld0,
   output logic [TAG_W-1:0]     o_idx1,
   output logic                 o_vld1
);

   // Scan from the top down: each free entry found becomes the new lowest,
   // pushing the previous lowest into the second slot.
   always_comb begin
      o_idx0 = '0;
      o_vld0 = 1'b0;
      o_idx1 = '0;
      o_vld1 = 1'b0;
      for (int i = RRF_DEPTH - 1; i >= 0; i--) begin
         if (!i_alloc[i]) begin
            o_idx1 = o_idx0;
            o_vld1 = o_vld0;
            o_idx0 = TAG_W'(i);
            o_vld0 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rename_register_file.sv
// 2-wide architectural register file with rename entries (map, writeback, commit).
// Latency: operand reads combinational; map/writeback/commit take effect at the clock edge; rrError one cycle after the request.
// Backpressure: none; rejected renames are reported on wrA_rrError/wrB_rrError and must be retried.
// Ports: clk/rst_n; wr_enable_*/wraddr*/writeData* writeback; map_en_*/wraddr*_map rename;
//        updateEn*/updateAddr* commit; addr*/data*/data*_ready operand reads; wr*_rrError rename reject.
// Optional: RF_WB_BYPASS_EN forwards same-cycle writeback data to matching busy reads.
module rename_register_file
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_enable_A,
   input  logic              wr_enable_B,
   input  logic [AREG_W-1:0] wraddrA,
   input  logic [AREG_W-1:0] wraddrB,
   input  logic [DATA_W-1:0] writeDataA,
   input  logic [DATA_W-1:0] writeDataB,
   input  logic              map_en_A,
   input  logic              map_en_B,
   input  logic [AREG_W-1:0] wraddrA_map,
   input  logic [AREG_W-1:0] wraddrB_map,
   input  logic              updateEnA,
   input  logic              updateEnB,
   input  logic [AREG_W-1:0] updateAddrA,
   input  logic [AREG_W-1:0] updateAddrB,
   input  logic [AREG_W-1:0] addrA_0,
   input  logic [AREG_W-1:0] addrA_1,
   input  logic [AREG_W-1:0] addrB_0,
   input  logic [AREG_W-1:0] addrB_1,
   output logic [DATA_W-1:0] dataA_0,
   output logic [DATA_W-1:0] dataA_1,
   output logic [DATA_W-1:0] dataB_0,
   output logic [DATA_W-1:0] dataB_1,
   output logic              dataA_0_ready,
   output logic              dataA_1_ready,
   output logic              dataB_0_ready,
   output logic              dataB_1_ready,
   output logic              wrA_rrError,
   output logic              wrB_rrError
);

   arf_entry_t r_arf [ARF_DEPTH];
   rrf_entry_t r_rrf [RRF_DEPTH];
   logic       r_err_a;
   logic       r_err_b;

   logic [RRF_DEPTH-1:0] w_alloc;
   logic [TAG_W-1:0]     w_free_idx0;
   logic [TAG_W-1:0]     w_free_idx1;
   logic                 w_free_vld0;
   logic                 w_free_vld1;

   always_comb begin
      for (int t = 0; t < RRF_DEPTH; t++) begin
         w_alloc[t] = r_rrf[t].alloc;
      end
   end

   rrf_free_list u_free_list (
      .i_alloc (w_alloc),
      .o_idx0  (w_free_idx0),
      .o_vld0  (w_free_vld0),
      .o_idx1  (w_free_idx1),
      .o_vld1  (w_free_vld1)
   );

   // ---------------- rename decisions (all against pre-edge state) ----------------
   logic             w_map_a;
   logic             w_map_b;
   logic             w_err_a;
   logic             w_err_b;
   logic [TAG_W-1:0] w_tag_b;
   logic             w_avail_b;
   logic             w_dup_b;

   // Slot B takes whatever slot A leaves behind.
   assign w_tag_b   = w_map_a ? w_free_idx1 : w_free_idx0;
   assign w_avail_b = w_map_a ? w_free_vld1 : w_free_vld0;
   assign w_dup_b   = map_en_A && (wraddrB_map == wraddrA_map);

   assign w_map_a = map_en_A && (wraddrA_map != '0) && !r_arf[wraddrA_map].busy && w_free_vld0;
   assign w_err_a = map_en_A && (wraddrA_map != '0) && (r_arf[wraddrA_map].busy || !w_free_vld0);

   assign w_map_b = map_en_B && (wraddrB_map != '0) && !r_arf[wraddrB_map].busy && w_avail_b && !w_dup_b;
   assign w_err_b = map_en_B && (wraddrB_map != '0) &&
                    (r_arf[wraddrB_map].busy || !w_avail_b || w_dup_b);

   // ---------------- writeback / commit decisions ----------------
   logic             w_wb_a;
   logic             w_wb_b;
   logic             w_cm_a;
   logic             w_cm_b;
   logic [TAG_W-1:0] w_wb_tag_a;
   logic [TAG_W-1:0] w_wb_tag_b;
   logic [TAG_W-1:0] w_cm_tag_a;
   logic [TAG_W-1:0] w_cm_tag_b;

   assign w_wb_tag_a = r_arf[wraddrA].tag;
   assign w_wb_tag_b = r_arf[wraddrB].tag;
   assign w_cm_tag_a = r_arf[updateAddrA].tag;
   assign w_cm_tag_b = r_arf[updateAddrB].tag;

   assign w_wb_a = wr_enable_A && r_arf[wraddrA].busy;
   assign w_wb_b = wr_enable_B && r_arf[wraddrB].busy;
   assign w_cm_a = updateEnA && r_arf[updateAddrA].busy && r_rrf[w_cm_tag_a].valid;
   // A duplicate commit from slot B is dropped so the entry is freed once.
   assign w_cm_b = updateEnB && r_arf[updateAddrB].busy && r_rrf[w_cm_tag_b].valid &&
                   !(updateEnA && (updateAddrA == updateAddrB));

   // ---------------- state update ----------------
   // Order matters: writeback first, then commit, so a commit in the same
   // cycle as a writeback to the same entry leaves it freed. Allocation only
   // targets entries free before the edge, so it never collides with the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ARF_DEPTH; i++) begin
            r_arf[i] <= '0;
         end
         for (int t = 0; t < RRF_DEPTH; t++) begin
            r_rrf[t] <= '0;
         end
         r_err_a <= 1'b0;
         r_err_b <= 1'b0;
      end else begin
         r_err_a <= w_err_a;
         r_err_b <= w_err_b;

         if (w_wb_a) begin
            r_rrf[w_wb_tag_a].data  <= writeDataA;
            r_rrf[w_wb_tag_a].valid <= 1'b1;
         end
         if (w_wb_b) begin
            r_rrf[w_wb_tag_b].data  <= writeDataB;
            r_rrf[w_wb_tag_b].valid <= 1'b1;
         end

         if (w_cm_a) begin
            r_arf[updateAddrA].data <= r_rrf[w_cm_tag_a].data;
            r_arf[updateAddrA].busy <= 1'b0;
            r_rrf[w_cm_tag_a].alloc <= 1'b0;
            r_rrf[w_cm_tag_a].valid <= 1'b0;
         end
         if (w_cm_b) begin
            r_arf[updateAddrB].data <= r_rrf[w_cm_tag_b].data;
            r_arf[updateAddrB].busy <= 1'b0;
            r_rrf[w_cm_tag_b].alloc <= 1'b0;
            r_rrf[w_cm_tag_b].valid <= 1'b0;
         end

         if (w_map_a) begin
            r_rrf[w_free_idx0].alloc <= 1'b1;
            r_rrf[w_free_idx0].valid <= 1'b0;
            r_arf[wraddrA_map].busy  <= 1'b1;
            r_arf[wraddrA_map].tag   <= w_free_idx0;
         end
         if (w_map_b) begin
            r_rrf[w_tag_b].alloc    <= 1'b1;
            r_rrf[w_tag_b].valid    <= 1'b0;
            r_arf[wraddrB_map].busy <= 1'b1;
            r_arf[wraddrB_map].tag  <= w_tag_b;
         end
      end
   end

   assign wrA_rrError = r_err_a;
   assign wrB_rrError = r_err_b;

   // ---------------- operand reads ----------------
   logic [AREG_W-1:0] w_rd_addr [4];
   logic [DATA_W-1:0] w_rd_data [4];
   logic              w_rd_rdy  [4];

   assign w_rd_addr[0] = addrA_0;
   assign w_rd_addr[1] = addrA_1;
   assign w_rd_addr[2] = addrB_0;
   assign w_rd_addr[3] = addrB_1;

   always_comb begin
      for (int p = 0; p < 4; p++) begin
         w_rd_data[p] = '0;
         w_rd_rdy[p]  = 1'b0;
         if (w_rd_addr[p] == '0) begin
            w_rd_rdy[p] = 1'b1;
         end else if (!r_arf[w_rd_addr[p]].busy) begin
            w_rd_data[p] = r_arf[w_rd_addr[p]].data;
            w_rd_rdy[p]  = 1'b1;
`ifdef RF_WB_BYPASS_EN
         // Slot B is checked first so it wins when both slots hit.
         end else if (wr_enable_B && (wraddrB == w_rd_addr[p])) begin
            w_rd_data[p] = writeDataB;
            w_rd_rdy[p]  = 1'b1;
         end else if (wr_enable_A && (wraddrA == w_rd_addr[p])) begin
            w_rd_data[p] = writeDataA;
            w_rd_rdy[p]  = 1'b1;
`endif
         end else if (r_rrf[r_arf[w_rd_addr[p]].tag].valid) begin
            w_rd_data[p] = r_rrf[r_arf[w_rd_addr[p]].tag].data;
            w_rd_rdy[p]  = 1'b1;
         end
      end
   end

   assign dataA_0       = w_rd_data[0];
   assign dataA_1       = w_rd_data[1];
   assign dataB_0       = w_rd_data[2];
   assign dataB_1       = w_rd_data[3];
   assign dataA_0_ready = w_rd_rdy[0];
   assign dataA_1_ready = w_rd_rdy[1];
   assign dataB_0_ready = w_rd_rdy[2];
   assign dataB_1_ready = w_rd_rdy[3];

endmodule

// File: tb/tb_rename_register_file.sv
// Bench for rename_register_file: table of per-cycle operations with expected
// read-back and rename-error results, plus a reset-mid-operation sequence.
module tb_rename_register_file;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_enable_A = 1'b0, wr_enable_B = 1'b0;
   logic [4:0]  wraddrA = '0, wraddrB = '0;
   logic [31:0] writeDataA = '0, writeDataB = '0;
   logic        map_en_A = 1'b0, map_en_B = 1'b0;
   logic [4:0]  wraddrA_map = '0, wraddrB_map = '0;
   logic        updateEnA = 1'b0, updateEnB = 1'b0;
   logic [4:0]  updateAddrA = '0, updateAddrB = '0;
   logic [4:0]  addrA_0 = '0, addrA_1 = '0, addrB_0 = '0, addrB_1 = '0;
   logic [31:0] dataA_0, dataA_1, dataB_0, dataB_1;
   logic        dataA_0_ready, dataA_1_ready, dataB_0_ready, dataB_1_ready;
   logic        wrA_rrError, wrB_rrError;

   rename_register_file dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_enable_A   (wr_enable_A),
      .wr_enable_B   (wr_enable_B),
      .wraddrA       (wraddrA),
      .wraddrB       (wraddrB),
      .writeDataA    (writeDataA),
      .writeDataB    (writeDataB),
      .map_en_A      (map_en_A),
      .map_en_B      (map_en_B),
      .wraddrA_map   (wraddrA_map),
      .wraddrB_map   (wraddrB_map),
      .updateEnA     (updateEnA),
      .updateEnB     (updateEnB),
      .updateAddrA   (updateAddrA),
      .updateAddrB   (updateAddrB),
      .addrA_0       (addrA_0),
      .addrA_1       (addrA_1),
      .addrB_0       (addrB_0),
      .addrB_1       (addrB_1),
      .dataA_0       (dataA_0),
      .dataA_1       (dataA_1),
      .dataB_0       (dataB_0),
      .dataB_1       (dataB_1),
      .dataA_0_ready (dataA_0_ready),
      .dataA_1_ready (dataA_1_ready),
      .dataB_0_ready (dataB_0_ready),
      .dataB_1_ready (dataB_1_ready),
      .wrA_rrError   (wrA_rrError),
      .wrB_rrError   (wrB_rrError)
   );

   always #5 clk = ~clk;

   // One cycle of operations and the state expected afterwards.
   // Reads: addrA_0 = ra, addrB_1 = ra, addrB_0 = rb, addrA_1 = rb.
   typedef struct packed {
      logic        ma;  logic [4:0] maa; logic mb;  logic [4:0] mba;
      logic        wa;  logic [4:0] waa; logic [31:0] wda;
      logic        wb;  logic [4:0] wba; logic [31:0] wdb;
      logic        ua;  logic [4:0] uaa; logic ub;  logic [4:0] uba;
      logic [4:0]  ra;  logic [4:0] rb;
      logic        ea;  logic eb;
      logic [31:0] da;  logic rda; logic [31:0] db; logic rdb;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_strobes();
      map_en_A = 1'b0; map_en_B = 1'b0;
      wr_enable_A = 1'b0; wr_enable_B = 1'b0;
      updateEnA = 1'b0; updateEnB = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      map_en_A = v.ma; wraddrA_map = v.maa; map_en_B = v.mb; wraddrB_map = v.mba;
      wr_enable_A = v.wa; wraddrA = v.waa; writeDataA = v.wda;
      wr_enable_B = v.wb; wraddrB = v.wba; writeDataB = v.wdb;
      updateEnA = v.ua; updateAddrA = v.uaa; updateEnB = v.ub; updateAddrB = v.uba;
      addrA_0 = v.ra; addrB_1 = v.ra; addrB_0 = v.rb; addrA_1 = v.rb;
   endtask

   task automatic compare(input string tag, input vec_t e);
      chk({tag, " errA"}, {31'd0, wrA_rrError}, {31'd0, e.ea});
      chk({tag, " errB"}, {31'd0, wrB_rrError}, {31'd0, e.eb});
      chk({tag, " A0 data"}, dataA_0, e.da);
      chk({tag, " A0 rdy"}, {31'd0, dataA_0_ready}, {31'd0, e.rda});
      chk({tag, " B1 data"}, dataB_1, e.da);
      chk({tag, " B1 rdy"}, {31'd0, dataB_1_ready}, {31'd0, e.rda});
      chk({tag, " B0 data"}, dataB_0, e.db);
      chk({tag, " B0 rdy"}, {31'd0, dataB_0_ready}, {31'd0, e.rdb});
      chk({tag, " A1 data"}, dataA_1, e.db);
      chk({tag, " A1 rdy"}, {31'd0, dataA_1_ready}, {31'd0, e.rdb});
   endtask

   initial begin
      vec_t v;
      //          ma   maa   mb   mba    wa   waa   wda           wb   wba   wdb           ua   uaa   ub   uba    ra    rb     ea   eb    da            rda  db            rdb
      // v0 rename x3 -> not ready
      tbl.push_back('{1'b1,5'd3, 1'b0,5'd0,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd3, 5'd0,  1'b0,1'b0, 32'h0,        1'b0,32'h0,        1'b1});
      // v1 writeback x3 -> served from rename entry
      tbl.push_back('{1'b0,5'd0, 1'b0,5'd0,  1'b1,5'd3, 32'hA5A5A5A5, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd3, 5'd7,  1'b0,1'b0, 32'hA5A5A5A5, 1'b1,32'h0,        1'b1});
      // v2 rename x7 on slot B
      tbl.push_back('{1'b0,5'd0, 1'b1,5'd7,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd7, 5'd3,  1'b0,1'b0, 32'h0,        1'b0,32'hA5A5A5A5, 1'b1});
      // v3 writeback x7 on slot B
      tbl.push_back('{1'b0,5'd0, 1'b0,5'd0,  1'b0,5'd0, 32'h0,        1'b1,5'd7, 32'h5A5A5A5A, 1'b0,5'd0, 1'b0,5'd0,  5'd3, 5'd7,  1'b0,1'b0, 32'hA5A5A5A5, 1'b1,32'h5A5A5A5A, 1'b1});
      // v4 commit x3 (A) and x7 (B)
      tbl.push_back('{1'b0,5'd0, 1'b0,5'd0,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b1,5'd7,  5'd3, 5'd7,  1'b0,1'b0, 32'hA5A5A5A5, 1'b1,32'h5A5A5A5A, 1'b1});
      // v5 both slots rename x3: A wins, B rejected
      tbl.push_back('{1'b1,5'd3, 1'b1,5'd3,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd3, 5'd7,  1'b0,1'b1, 32'h0,        1'b0,32'h5A5A5A5A, 1'b1});
      // v6 both slots write x3: B wins; error pulse has ended
      tbl.push_back('{1'b0,5'd0, 1'b0,5'd0,  1'b1,5'd3, 32'h11111111, 1'b1,5'd3, 32'h22222222, 1'b0,5'd0, 1'b0,5'd0,  5'd3, 5'd0,  1'b0,1'b0, 32'h22222222, 1'b1,32'h0,        1'b1});
      // v7 commit x3 on both slots plus rename x3: commit done, rename rejected
      tbl.push_back('{1'b1,5'd3, 1'b0,5'd0,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b1,5'd3,  5'd3, 5'd5,  1'b1,1'b0, 32'h22222222, 1'b1,32'h0,        1'b1});
      // v8..v11 fill all eight entries: x1,x2,x4..x9
      tbl.push_back('{1'b1,5'd1, 1'b1,5'd2,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd1, 5'd2,  1'b0,1'b0, 32'h0,        1'b0,32'h0,        1'b0});
      tbl.push_back('{1'b1,5'd4, 1'b1,5'd5,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd4, 5'd3,  1'b0,1'b0, 32'h0,        1'b0,32'h22222222, 1'b1});
      tbl.push_back('{1'b1,5'd6, 1'b1,5'd7,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd7, 5'd6,  1'b0,1'b0, 32'h0,        1'b0,32'h0,        1'b0});
      tbl.push_back('{1'b1,5'd8, 1'b1,5'd9,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd9, 5'd8,  1'b0,1'b0, 32'h0,        1'b0,32'h0,        1'b0});
      // v12 ninth rename (x3) finds no entry; remap of busy x1 rejected
      tbl.push_back('{1'b1,5'd3, 1'b1,5'd1,  1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd3, 5'd1,  1'b1,1'b1, 32'h22222222, 1'b1,32'h0,        1'b0});
      // v13 write x5; write to idle x3 ignored; commit of unwritten x9 ignored
      tbl.push_back('{1'b0,5'd0, 1'b0,5'd0,  1'b1,5'd5, 32'hDEADBEEF, 1'b1,5'd3, 32'h33333333, 1'b1,5'd9, 1'b0,5'd0,  5'd5, 5'd3,  1'b0,1'b0, 32'hDEADBEEF, 1'b1,32'h22222222, 1'b1});
      // v14 writeback+commit same cycle: x5 commits old data, x9 commit ignored but written
      tbl.push_back('{1'b0,5'd0, 1'b0,5'd0,  1'b1,5'd5, 32'h12345678, 1'b1,5'd9, 32'hCAFEF00D, 1'b1,5'd5, 1'b1,5'd9,  5'd5, 5'd9,  1'b0,1'b0, 32'hDEADBEEF, 1'b1,32'hCAFEF00D, 1'b1});
      // v15 one entry free: A gets it, B rejected
      tbl.push_back('{1'b1,5'd11,1'b1,5'd12, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0,  5'd11,5'd9,  1'b0,1'b1, 32'h0,        1'b0,32'hCAFEF00D, 1'b1});

      // Reset state.
      repeat (2) @(posedge clk);
      #1 addrA_0 = 5'd3; addrB_0 = 5'd0; addrA_1 = 5'd31; addrB_1 = 5'd1;
      #1;
      chk("reset errA", {31'd0, wrA_rrError}, 32'd0);
      chk("reset errB", {31'd0, wrB_rrError}, 32'd0);
      chk("reset x3 data", dataA_0, 32'd0);
      chk("reset x3 rdy", {31'd0, dataA_0_ready}, 32'd1);
      chk("reset x31 rdy", {31'd0, dataA_1_ready}, 32'd1);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         apply(tbl[i]);
         exp_q.push_back(tbl[i]);
         @(posedge clk);
         #1 clear_strobes();
         #1;
         v = exp_q.pop_front();
         compare($sformatf("v%0d", i), v);
      end

      // Reset mid-operation: all mappings and the pending error pulse vanish.
      @(negedge clk);
      rst_n = 1'b0;
      addrA_0 = 5'd1; addrB_1 = 5'd1; addrB_0 = 5'd9; addrA_1 = 5'd9;
      #1;
      v = '0;
      v.rda = 1'b1; v.rdb = 1'b1;
      compare("midrst", v);

      // After release every entry is free again; a same-register B is still rejected.
      @(negedge clk);
      rst_n = 1'b1;
      map_en_A = 1'b1; wraddrA_map = 5'd1; map_en_B = 1'b1; wraddrB_map = 5'd1;
      @(posedge clk);
      #1 clear_strobes();
      #1;
      v = '0;
      v.eb = 1'b1; v.rdb = 1'b1; v.rda = 1'b0;
      compare("postrst", v);

      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
